// File: rtl/status_flag_if.sv
// Execute-stage ALU command bus into the NZCV status unit, with result/status return.
interface status_flag_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic [3:0]       exe_cmd;
  logic             s_bit;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             shifter_carry;
  logic             stall;
  logic             flush;
  logic             msr_en;
  logic [3:0]       msr_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       status;
  logic [3:0]       status_fwd;

  modport master (
    output in_valid, exe_cmd, s_bit, op1, op2, shifter_carry, stall, flush, msr_en, msr_data,
    input  out_valid, out_result, status, status_fwd
  );
  modport slave (
    input  in_valid, exe_cmd, s_bit, op1, op2, shifter_carry, stall, flush, msr_en, msr_data,
    output out_valid, out_result, status, status_fwd
  );
endinterface

// File: rtl/status_flag_unit.sv
// ALU result + NZCV flag generation; owns the architectural status register
// and forwards its next value for back-to-back dependent instructions.
module status_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  status_flag_if.slave bus
);
  localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001;
  localparam logic [3:0] C_ADD = 4'b0010, C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100, C_SBC = 4'b0101;
  localparam logic [3:0] C_AND = 4'b0110, C_ORR = 4'b0111, C_EOR = 4'b1000;

  logic [3:0]       status_q, status_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;

  logic             cin, arith, is_sub, passthru, cadd, eff;
  logic [WIDTH-1:0] opb, res;
  logic [WIDTH:0]   sum;
  logic [3:0]       flags;

  always_comb begin
    cin      = status_q[1];  // carry always from the register, never from status_fwd
    arith    = 1'b0;
    is_sub   = 1'b0;
    passthru = 1'b0;
    cadd     = 1'b0;
    unique case (bus.exe_cmd)
      C_ADD: arith = 1'b1;
      C_ADC: begin arith = 1'b1; cadd = cin; end
      C_SUB: begin arith = 1'b1; is_sub = 1'b1; cadd = 1'b1; end
      C_SBC: begin arith = 1'b1; is_sub = 1'b1; cadd = cin; end
      C_MOV, C_MVN, C_AND, C_ORR, C_EOR: passthru = 1'b1;
      default: ;
    endcase

    // Subtraction as op1 + ~op2 + carry_in, so C comes out as NOT borrow
    opb = is_sub ? ~bus.op2 : bus.op2;
    sum = {1'b0, bus.op1} + {1'b0, opb} + {{WIDTH{1'b0}}, cadd};

    res = '0;
    unique case (bus.exe_cmd)
      C_MOV: res = bus.op2;
      C_MVN: res = ~bus.op2;
      C_AND: res = bus.op1 & bus.op2;
      C_ORR: res = bus.op1 | bus.op2;
      C_EOR: res = bus.op1 ^ bus.op2;
      C_ADD, C_ADC, C_SUB, C_SBC: res = sum[WIDTH-1:0];
      default: ;
    endcase

    flags = status_q;
    if (arith)
      flags = {res[WIDTH-1], res == '0, sum[WIDTH],
               (bus.op1[WIDTH-1] == opb[WIDTH-1]) && (res[WIDTH-1] != bus.op1[WIDTH-1])};
    else if (passthru)
      flags = {res[WIDTH-1], res == '0, bus.shifter_carry, status_q[0]};

    eff = bus.in_valid & ~bus.flush & ~bus.stall;

    status_d     = status_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    if (!bus.stall) begin
      if (bus.msr_en)          status_d = bus.msr_data;
      else if (eff && bus.s_bit) status_d = flags;
      out_valid_d = bus.in_valid & ~bus.flush;
      if (eff) out_result_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q     <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      status_q     <= status_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  assign bus.status     = status_q;
  assign bus.status_fwd = status_d;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
endmodule
